// File: rtl/uart_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pattern_gen
// Purpose  : Burst traffic generator (increment/constant/LFSR/walking-one)
//            with a valid/ready output that supports backpressure.
//            The optional GEN_CHECKSUM_EN macro appends a sum beat to each burst.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_pattern_gen #(
  parameter int                DATA_W       = 8,
  parameter int                INTERVAL_CYC = 500_000,
  parameter int                BURST_LEN    = 1,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = DATA_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              burst_done_o,
  output logic [15:0]       burst_cnt_o
);

  localparam int                 C_TIMER_W    = (INTERVAL_CYC > 1) ? $clog2(INTERVAL_CYC) : 1;
  localparam logic [C_TIMER_W-1:0] C_TIMER_LAST = C_TIMER_W'(INTERVAL_CYC - 1);
  localparam logic [15:0]        C_LAST_BEAT  = 16'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                state_q;
  logic [C_TIMER_W-1:0]  timer_q;
  logic [15:0]           beat_q;
  logic [DATA_W-1:0]     pat_q;
  logic [DATA_W-1:0]     data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [15:0]           cnt_q;
  logic [1:0]            mode_q;
`ifdef GEN_CHECKSUM_EN
  logic [DATA_W-1:0]     sum_q;
  logic                  chk_q;
`endif

  logic [DATA_W-1:0]     pat_adv_d;
  logic [DATA_W-1:0]     pat_load_d;
  logic                  xfer;

  assign xfer = valid_q && ready_i;

  always_comb begin
    pat_adv_d = pat_q;
    case (mode_q)
      2'd0:    pat_adv_d = pat_q + 1'b1;
      2'd1:    pat_adv_d = pat_q;
      2'd2:    pat_adv_d = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
      default: pat_adv_d = {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
    endcase
  end

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  always_comb begin
    pat_load_d = seed_i;
    case (mode_i)
      2'd2:    pat_load_d = (seed_i == '0) ? DATA_W'(1) : seed_i;
      2'd3:    pat_load_d = DATA_W'(1);
      default: pat_load_d = seed_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      beat_q  <= '0;
      pat_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
`ifdef GEN_CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            mode_q  <= mode_i;
            pat_q   <= pat_load_d;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (timer_q == C_TIMER_LAST) begin
            state_q <= S_SEND;
            beat_q  <= '0;
            valid_q <= 1'b1;
            data_q  <= pat_q;
`ifdef GEN_CHECKSUM_EN
            sum_q   <= '0;
            chk_q   <= 1'b0;
`endif
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_SEND: begin
          if (xfer) begin
`ifdef GEN_CHECKSUM_EN
            if (chk_q) begin
              chk_q   <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              valid_q <= 1'b0;
              timer_q <= '0;
              state_q <= enable_i ? S_WAIT : S_IDLE;
              busy_q  <= enable_i;
            end else begin
              pat_q  <= pat_adv_d;
              beat_q <= beat_q + 1'b1;
              sum_q  <= sum_q + data_q;
              // The sum beat goes out even if enable has already dropped.
              if (beat_q == C_LAST_BEAT) begin
                chk_q  <= 1'b1;
                data_q <= sum_q + data_q;
              end else if (!enable_i) begin
                valid_q <= 1'b0;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                data_q <= pat_adv_d;
              end
            end
`else
            pat_q  <= pat_adv_d;
            beat_q <= beat_q + 1'b1;
            if (beat_q == C_LAST_BEAT) begin
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              valid_q <= 1'b0;
              timer_q <= '0;
              state_q <= enable_i ? S_WAIT : S_IDLE;
              busy_q  <= enable_i;
            end else if (!enable_i) begin
              valid_q <= 1'b0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              data_q <= pat_adv_d;
            end
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = busy_q;
  assign burst_done_o = done_q;
  assign burst_cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_pattern_gen
// Purpose  : Scoreboard bench for uart_tx_pattern_gen (INTERVAL 10, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_pattern_gen;

  localparam int DATA_W   = 8;
  localparam int INTERVAL = 10;
  localparam int BLEN     = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable_i = 1'b0;
  logic        ready_i  = 1'b0;
  logic [1:0]  mode_i   = 2'd0;
  logic [7:0]  seed_i   = 8'h00;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        busy_o;
  logic        burst_done_o;
  logic [15:0] burst_cnt_o;

  int         n_cmp     = 0;
  int         n_bad     = 0;
  int         done_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_pattern_gen #(
    .DATA_W      (DATA_W),
    .INTERVAL_CYC(INTERVAL),
    .BURST_LEN   (BLEN),
    .LFSR_TAPS   (8'hB8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .mode_i      (mode_i),
    .seed_i      (seed_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .burst_done_o(burst_done_o),
    .burst_cnt_o (burst_cnt_o)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat is matched against the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (burst_done_o) done_seen++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", data_o);
        end else begin
          check("beat_data", data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s;
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    s = a + b + c + d;
`ifdef GEN_CHECKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  task automatic start_run(input logic [1:0] m, input logic [7:0] s);
    @(posedge clk);
    #2;
    mode_i   = m;
    seed_i   = s;
    enable_i = 1'b1;
  endtask

  // Returns one time unit after the edge at which valid rose; n counts edges.
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (valid_o) break;
    end
    if (!valid_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: got no valid after %0d edges, expected valid", n);
    end
  endtask

  task automatic wait_bursts(input int target);
    int t = 0;
    while (done_seen < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("burst_done_count", done_seen, target);
  endtask

  task automatic stop_run();
    int t = 0;
    @(posedge clk);
    #2;
    enable_i = 1'b0;
    while (busy_o && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stop_busy", busy_o, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    int cnt0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", burst_done_o, 0);
    check("rst_cnt", burst_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment run, two bursts; valid appears after the sampling edge + INTERVAL
    ready_i = 1'b1;
    push4(8'h10, 8'h11, 8'h12, 8'h13);
    push4(8'h14, 8'h15, 8'h16, 8'h17);
    start_run(2'd0, 8'h10);
    wait_valid(n);
    check("t1_first_latency", n, INTERVAL + 1);
    check("t1_first_word", data_o, 8'h10);
    n = 0;
    while (!burst_done_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_done_pulse", burst_done_o, 1);
    check("t1_cnt1", burst_cnt_o, 1);
    wait_valid(n);
    check("t1_gap", n, INTERVAL);
    wait_bursts(2);
    check("t1_cnt2", burst_cnt_o, 2);
    stop_run();

    // Backpressure on the second beat
    @(posedge clk);
    #2;
    ready_i = 1'b0;
    base = done_seen;
    push4(8'h10, 8'h11, 8'h12, 8'h13);
    start_run(2'd0, 8'h10);
    wait_valid(n);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", valid_o, 1);
      check("t2_hold_data", data_o, 8'h11);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("t2_next_valid", valid_o, 1);
    check("t2_next_data", data_o, 8'h12);
    wait_bursts(base + 1);
    stop_run();

    // LFSR from a zero seed
    base = done_seen;
    push4(8'h01, 8'hB8, 8'h5C, 8'h2E);
    start_run(2'd2, 8'h00);
    wait_bursts(base + 1);
    stop_run();

    // Increment wrap
    base = done_seen;
    push4(8'hFE, 8'hFF, 8'h00, 8'h01);
    start_run(2'd0, 8'hFE);
    wait_bursts(base + 1);
    stop_run();

    // Walking one across three bursts; seed must be ignored
    base = done_seen;
    push4(8'h01, 8'h02, 8'h04, 8'h08);
    push4(8'h10, 8'h20, 8'h40, 8'h80);
    push4(8'h01, 8'h02, 8'h04, 8'h08);
    start_run(2'd3, 8'h55);
    wait_bursts(base + 3);
    check("t4_cnt", burst_cnt_o, 8);
    stop_run();

    // Enable drop mid-burst while stalled on beat 1
    @(posedge clk);
    #2;
    ready_i = 1'b0;
    base = done_seen;
    cnt0 = int'(burst_cnt_o);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    start_run(2'd0, 8'h20);
    wait_valid(n);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i  = 1'b0;
    enable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_stall_valid", valid_o, 1);
    check("t5_stall_data", data_o, 8'h21);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_low", valid_o, 0);
    check("t5_busy_low", busy_o, 0);
    check("t5_cnt_same", burst_cnt_o, cnt0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_seen, base);
    check("t5_queue_drained", exp_q.size(), 0);

    // Asynchronous reset while a beat is pending
    ready_i = 1'b0;
    start_run(2'd0, 8'h10);
    wait_valid(n);
    check("t6_busy_before", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", valid_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_data", data_o, 0);
    check("t6_cnt", burst_cnt_o, 0);
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
